// File: rtl/mlp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mlp_pkg: shared widths and layer sequencer state encoding.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mlp_pkg;

  localparam int DATA_W   = 8;
  localparam int ACC_W    = 16;
  localparam int NEUR_W   = 8;
  localparam int W_ADDR_W = 16;

  typedef enum logic [2:0] {
    LS_IDLE  = 3'd0,
    LS_ISSUE = 3'd1,
    LS_WAIT  = 3'd2,
    LS_WRITE = 3'd3,
    LS_DONE  = 3'd4
  } layer_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/layer_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | layer_addr_gen: input index and weight base for the current neuron.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module layer_addr_gen #(
  parameter int W_ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                step,
  input  logic                next_neuron,
  input  logic [7:0]          stride,
  output logic [7:0]          x_addr,
  output logic [W_ADDR_W-1:0] w_addr
);
  import mlp_pkg::*;

  logic [7:0]          in_idx_q, in_idx_d;
  logic [W_ADDR_W-1:0] w_base_q, w_base_d;

  always_comb begin
    in_idx_d = in_idx_q;
    w_base_d = w_base_q;
    if (clear) begin
      in_idx_d = '0;
      w_base_d = '0;
    end else if (next_neuron) begin
      in_idx_d = '0;
      w_base_d = w_base_q + W_ADDR_W'(stride);
    end else if (step) begin
      in_idx_d = in_idx_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_idx_q <= '0;
      w_base_q <= '0;
    end else begin
      in_idx_q <= in_idx_d;
      w_base_q <= w_base_d;
    end
  end

  // Weight rows are packed back to back; the sum wraps modulo the address space.
  assign x_addr = in_idx_q;
  assign w_addr = w_base_q + W_ADDR_W'(in_idx_q);

endmodule
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | layer_sequencer: issues one neuron per output and stores results.  |
// | Option macro: LAYER_SEQ_RELU_EN (clamp negative results to zero).  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module layer_sequencer #(
  parameter int DATA_W   = mlp_pkg::DATA_W,
  parameter int ACC_W    = mlp_pkg::ACC_W,
  parameter int NEUR_W   = mlp_pkg::NEUR_W,
  parameter int W_ADDR_W = mlp_pkg::W_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                layer_start,
  input  logic [NEUR_W-1:0]   num_neurons,
  input  logic [7:0]          num_inputs,
  output logic                layer_busy,
  output logic                layer_done,
  output logic                neuron_start,
  output logic [15:0]         neuron_n,
  input  logic                neuron_load,
  input  logic                neuron_ready,
  input  logic [ACC_W-1:0]    neuron_result,
  output logic [7:0]          x_addr,
  output logic [W_ADDR_W-1:0] w_addr,
  output logic                res_we,
  output logic [NEUR_W-1:0]   res_addr,
  output logic [ACC_W-1:0]    res_data
);
  import mlp_pkg::*;

  if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
    $error("layer_sequencer: ACC_W too narrow for DATA_W products");
  end

  layer_seq_state_t    state_q, state_d;
  logic [NEUR_W-1:0]   num_neurons_q, num_neurons_d;
  logic [7:0]          num_inputs_q, num_inputs_d;
  logic [NEUR_W-1:0]   neur_idx_q, neur_idx_d;
  logic [ACC_W-1:0]    result_q, result_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                start_q, start_d;
  logic                res_we_q, res_we_d;
  logic                ag_clear, ag_step, ag_next;

  always_comb begin
    state_d       = state_q;
    num_neurons_d = num_neurons_q;
    num_inputs_d  = num_inputs_q;
    neur_idx_d    = neur_idx_q;
    result_d      = result_q;
    ag_clear      = 1'b0;
    ag_step       = 1'b0;
    ag_next       = 1'b0;
    case (state_q)
      LS_IDLE: begin
        if (layer_start) begin
          num_neurons_d = num_neurons;
          num_inputs_d  = num_inputs;
          neur_idx_d    = '0;
          ag_clear      = 1'b1;
          state_d       = (num_neurons == '0) ? LS_DONE : LS_ISSUE;
        end
      end
      LS_ISSUE: begin
        // The neuron controller wraps on N=0, so empty neurons bypass it.
        if (num_inputs_q == 8'd0) begin
          result_d = '0;
          state_d  = LS_WRITE;
        end else begin
          state_d  = LS_WAIT;
        end
      end
      LS_WAIT: begin
        if (neuron_ready) begin
          result_d = neuron_result;
          state_d  = LS_WRITE;
        end else if (neuron_load) begin
          ag_step = 1'b1;
        end
      end
      LS_WRITE: begin
        ag_next    = 1'b1;
        neur_idx_d = neur_idx_q + NEUR_W'(1);
        state_d    = (neur_idx_q == num_neurons_q - NEUR_W'(1)) ? LS_DONE : LS_ISSUE;
      end
      LS_DONE: state_d = LS_IDLE;
      default: state_d = LS_IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    busy_d   = (state_d != LS_IDLE);
    done_d   = (state_d == LS_DONE);
    start_d  = (state_d == LS_ISSUE) && (num_inputs_d != 8'd0);
    res_we_d = (state_d == LS_WRITE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= LS_IDLE;
      num_neurons_q <= '0;
      num_inputs_q  <= '0;
      neur_idx_q    <= '0;
      result_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      start_q       <= 1'b0;
      res_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      num_neurons_q <= num_neurons_d;
      num_inputs_q  <= num_inputs_d;
      neur_idx_q    <= neur_idx_d;
      result_q      <= result_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      start_q       <= start_d;
      res_we_q      <= res_we_d;
    end
  end

  layer_addr_gen #(
    .W_ADDR_W(W_ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (ag_clear),
    .step       (ag_step),
    .next_neuron(ag_next),
    .stride     (num_inputs_q),
    .x_addr     (x_addr),
    .w_addr     (w_addr)
  );

  assign layer_busy   = busy_q;
  assign layer_done   = done_q;
  assign neuron_start = start_q;
  assign neuron_n     = {8'b0, num_inputs_q};
  assign res_we       = res_we_q;
  assign res_addr     = neur_idx_q;

`ifdef LAYER_SEQ_RELU_EN
  assign res_data = result_q[ACC_W-1] ? '0 : result_q;
`else
  assign res_data = result_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_layer_sequencer: directed scoreboard bench for layer_sequencer. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_layer_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        layer_start = 1'b0;
  logic [7:0]  num_neurons = '0;
  logic [7:0]  num_inputs = '0;
  logic        layer_busy, layer_done, neuron_start;
  logic [15:0] neuron_n;
  logic        neuron_load = 1'b0;
  logic        neuron_ready = 1'b0;
  logic [15:0] neuron_result = '0;
  logic [7:0]  x_addr;
  logic [15:0] w_addr;
  logic        res_we;
  logic [7:0]  res_addr;
  logic [15:0] res_data;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  layer_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .layer_start  (layer_start),
    .num_neurons  (num_neurons),
    .num_inputs   (num_inputs),
    .layer_busy   (layer_busy),
    .layer_done   (layer_done),
    .neuron_start (neuron_start),
    .neuron_n     (neuron_n),
    .neuron_load  (neuron_load),
    .neuron_ready (neuron_ready),
    .neuron_result(neuron_result),
    .x_addr       (x_addr),
    .w_addr       (w_addr),
    .res_we       (res_we),
    .res_addr     (res_addr),
    .res_data     (res_data)
  );

  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef LAYER_SEQ_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {layer_busy, layer_done, neuron_start, res_we, neuron_n, x_addr, w_addr,
              res_addr, res_data}, '0);
  endtask

  // One layer with a behavioural neuron controller; rst_cyc >= 0 aborts by reset.
  task automatic run_layer(input int m, input int n, input logic [15:0] rbase,
                           input int exp_done, input int inj_cyc, input int rst_cyc,
                           input int exp_starts, input int exp_writes);
    int  t0 = 0, nidx = 0, starts = 0, writes = 0;
    bit  active = 0, done = 0;
    wr_t w;
    @(posedge clk); #1;
    num_neurons = 8'(m);
    num_inputs  = 8'(n);
    layer_start = 1'b1;
    if (n == 0)
      for (int i = 0; i < m; i++) sb.push_back('{addr: 8'(i), data: 16'h0000});
    for (int c = 1; c <= exp_done + 10 && !done; c++) begin
      @(posedge clk); #1;
      layer_start  = 1'b0;
      num_neurons  = 8'(m);
      num_inputs   = 8'(n);
      neuron_load  = 1'b0;
      neuron_ready = 1'b0;
      if (neuron_start) begin
        starts++;
        t0 = c;
        active = 1;
        chk("start_n", 32'(neuron_n), 32'(n));
        chk("start_x_addr", 32'(x_addr), 0);
      end
      if (res_we) begin
        writes++;
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'(res_addr), 32'hFFFF_FFFF);
        end else begin
          w = sb.pop_front();
          chk("res_addr", 32'(res_addr), 32'(w.addr));
          chk("res_data", 32'(res_data), 32'(w.data));
        end
      end
      if (layer_done) begin
        chk("done_cycle", c, exp_done);
        done = 1;
      end
      if (active && c > t0 && c <= t0 + 2 * n - 1 && ((c - t0) % 2) == 1) begin
        neuron_load = 1'b1;
        chk("load_x_addr", 32'(x_addr), (c - t0 - 1) / 2);
        chk("load_w_addr", 32'(w_addr), nidx * n + (c - t0 - 1) / 2);
      end else if (active && c == t0 + 2 * n + 1) begin
        neuron_ready  = 1'b1;
        neuron_result = rbase + 16'(nidx);
        sb.push_back('{addr: 8'(nidx), data: relu(rbase + 16'(nidx))});
        nidx++;
        active = 0;
      end
      if (c == inj_cyc) begin
        layer_start = 1'b1;
        num_neurons = 8'd7;
        num_inputs  = 8'd5;
      end
      if (c == rst_cyc) begin
        rst = 1'b1;
        done = 1;
      end
    end
    neuron_load  = 1'b0;
    neuron_ready = 1'b0;
    layer_start  = 1'b0;
    if (rst_cyc >= 0) begin
      #1;
      chk_quiet("reset_outputs");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        chk("post_reset_idle", {layer_busy, layer_done, neuron_start, res_we, x_addr, w_addr}, '0);
      end
      sb.delete();
    end else begin
      chk("done_seen", 32'(done), 1);
      @(posedge clk); #1;
      chk("idle_after_done", {layer_busy, layer_done}, 0);
      chk("sb_drained", sb.size(), 0);
    end
    chk("start_count", starts, exp_starts);
    chk("write_count", writes, exp_writes);
  endtask

  initial begin
    #2;
    chk_quiet("reset_state");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_quiet("idle_after_reset");

    // M=1, N=3
    run_layer(1, 3, 16'h0042, 10, -1, -1, 1, 1);
    // M=3, N=2: weight bases 0, 2, 4
    run_layer(3, 2, 16'h0100, 22, -1, -1, 3, 3);
    // M=2, N=0: no starts, zero results
    run_layer(2, 0, 16'h1234, 5, -1, -1, 0, 2);
    // M=0: immediate done
    run_layer(0, 3, 16'h0000, 1, -1, -1, 0, 0);
    // Negative result, ReLU-dependent
    run_layer(1, 1, 16'hFF80, 6, -1, -1, 1, 1);
    // Mid-layer start ignored, then reset during WAIT of neuron 1
    run_layer(3, 2, 16'h0010, 22, 9, 12, 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/layer_sequencer.md
# layer_sequencer

Initiator side of the neuron start/ready handshake. Given a layer request, issues one neuron computation per output neuron and drives the input and weight memory addresses in step with the neuron controller's load strobes. After each neuron, captures the accumulated result and writes it to the layer result buffer. Sits between the top-level network FSM and the single-neuron datapath/controller pair.

## Interface
- `DATA_W`, default 8: input/weight word width.
- `ACC_W`, default 16: neuron accumulator/result width (two's complement).
- `NEUR_W`, default 8: neuron index width; at most 2^NEUR_W−1 neurons.
- `W_ADDR_W`, default 16: weight memory address width.
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-high.
- `layer_start` in 1: begin layer; honoured only in IDLE.
- `num_neurons` in NEUR_W: neurons in layer; sampled on accepted `layer_start`.
- `num_inputs` in 8: inputs per neuron; sampled on accepted `layer_start`.
- `layer_busy` out 1: high in every state except IDLE.
- `layer_done` out 1: one-cycle pulse at end of layer.
- `neuron_start` out 1: one-cycle start to the neuron controller.
- `neuron_n` out 16: `{8'b0, num_inputs_q}`; driven to the neuron controller's N.
- `neuron_load` in 1: neuron controller's input-register strobe.
- `neuron_ready` in 1: neuron controller's ready.
- `neuron_result` in ACC_W: accumulator value; valid while `neuron_ready`=1.
- `x_addr` out 8: input memory address (combinational-read memory).
- `w_addr` out W_ADDR_W: weight memory address (combinational-read memory).
- `res_we` out 1: result buffer write enable.
- `res_addr` out NEUR_W: result buffer address (neuron index).
- `res_data` out ACC_W: result buffer write data.

## Operation
- States: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE:
  - On `layer_start`: latch `num_neurons_q`, `num_inputs_q`; clear `neur_idx`, `in_idx`, `w_base`.
  - Then go to DONE if `num_neurons`=0, else ISSUE.
- ISSUE:
  - If `num_inputs_q`≠0: `neuron_start`=1 for one cycle, then WAIT.
  - If `num_inputs_q`=0: no start; result register forced to 0; go to WRITE. The neuron controller wraps on N=0 and must never see it.
- WAIT:
  - Each `neuron_load` cycle: `in_idx`++ (registered). The current address is valid during the load cycle.
  - On `neuron_ready`: capture `neuron_result` into the result register; go to WRITE.
  - `neuron_load` and `neuron_ready` are never asserted together; if they are, ready wins.
- WRITE:
  - `res_we`=1, `res_addr`=`neur_idx`, `res_data`=result register.
  - Update indices: `w_base` += `num_inputs_q`, `neur_idx`++, `in_idx`=0.
  - Go to DONE if `neur_idx`=`num_neurons_q`−1, else ISSUE.
- DONE: `layer_done`=1 for one cycle, then IDLE.
- Address outputs: `x_addr`=`in_idx`; `w_addr`=`w_base`+`in_idx` (zero-extended; wraps modulo 2^W_ADDR_W).
- `layer_start` while busy is ignored; latched parameters do not change mid-layer.
- Reset at any time: state returns to IDLE. All outputs are 0, except `neuron_n`=0. All index and result registers are 0.

## Timing
- `layer_start` at cycle 0 puts the block in ISSUE at cycle 1.
- Per neuron with N≥1 inputs: ISSUE at t, loads at t+1, t+3, …, t+2N−1, ready at t+2N+1, WRITE at t+2N+2, next ISSUE at t+2N+3. That is 2N+3 cycles per neuron.
- Per neuron with N=0: 2 cycles (ISSUE, WRITE).
- Layer with M≥1 neurons: `layer_done` at cycle 1+M·(2N+3); IDLE the following cycle.
- Layer with M=0: `layer_done` at cycle 1.
- `res_we` is high for exactly one cycle per neuron.

## Configuration
- `LAYER_SEQ_RELU_EN`:
  - Defined: `res_data` = result register if its MSB is 0, else 0.
  - Undefined: `res_data` = raw result register (signed value passed through).

## Structure
- Shared package `mlp_pkg`:
  - state enum `layer_seq_state_t`;
  - width constants `DATA_W`, `ACC_W`, `NEUR_W`, `W_ADDR_W`.
- Sub-module `layer_addr_gen`: holds `in_idx` and `w_base`, with clear/step/next-neuron controls. Produces `x_addr` and `w_addr`.

## Test plan
- M=1, N=3, result 0x0042 at ready: expect loads with `x_addr`=0,1,2 and `w_addr`=0,1,2. Expect one write, addr 0, data 0x0042. Expect `layer_done` at cycle 10.
- M=3, N=2: expect `w_addr` bases 0, 2, 4 and writes at addrs 0, 1, 2. Expect `layer_done` at cycle 22.
- M=2, N=0: expect no `neuron_start` and writes of 0 at addrs 0 and 1. Expect `layer_done` at cycle 5.
- M=0: expect `layer_done` at cycle 1 and no start or write.
- Result 0xFF80 with `LAYER_SEQ_RELU_EN` defined: `res_data`=0x0000. With it undefined: `res_data`=0xFF80.
- Reset asserted during WAIT of neuron 1 of 3, and `layer_start` pulsed mid-layer: after reset, IDLE, all outputs 0, no further `res_we`. The mid-layer `layer_start` has no effect on the indices.
